vram_blit_arb: RTL
==================

Name: vram_blit_arb

Overview:
- Sits between the CPU Wishbone-style bus and the CPU-side port of the text VRAM (1200 words, 32 bits each).
- Shares that single-port interface between CPU accesses and a built-in fill/scroll engine. The engine clears the screen to a fill word or scrolls up by one text row.
- CPU has strict per-cycle priority; the engine runs only in cycles the CPU leaves idle.
- The VGA read port of the VRAM is untouched.

Parameters:
- COLS, 40, words per text row
- ROWS, 30, text rows; WORDS = COLS*ROWS = 1200
- AW, 11, word index width; byte address = index<<2

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock, asynchronous, active-high
- cpu_dat_i  in  32  CPU write data
- cpu_adr_i  in  32  CPU byte address
- cpu_we_i  in  1  CPU write enable
- cpu_stb_i  in  1  CPU strobe
- cpu_dat_o  out  32  CPU read data (VRAM data passthrough)
- cpu_ack_o  out  1  CPU acknowledge
- cmd_valid  in  1  start-command pulse
- cmd_op  in  1  command: 0 = clear, 1 = scroll up one row
- fill_word  in  32  fill value, sampled with cmd_valid
- busy  out  1  engine active
- done  out  1  one-cycle pulse when the engine finishes
- vram_dat_o  out  32  to VRAM dat_i
- vram_adr_o  out  32  to VRAM adr_i
- vram_we_o  out  1  to VRAM we_i
- vram_stb_o  out  1  to VRAM stb_i
- vram_dat_i  in  32  from VRAM dat_o

Behaviour:
- Reset values: busy=0, done=0, engine state IDLE, index=0. Reset mid-operation aborts the engine; words already written stay written.
- cpu_ack_o = cpu_stb_i (combinational). cpu_dat_o = vram_dat_i.
- Bus mux:
  - When cpu_stb_i=1, the vram_* outputs carry the CPU signals in that same cycle.
  - Otherwise they carry the engine's signals.
  - When neither drives the bus, stb=0 and we=0.
- VRAM access timing rules:
  - Every engine access holds stb, adr and we constant for 2 consecutive cycles (an access pair).
  - Read data is valid on vram_dat_i in the cycle after the pair.
  - A write commits at the end of the second cycle.
- Preemption: if cpu_stb_i rises during an engine pair, that pair is aborted and restarted from its first cycle.
- Guard: after any cycle with cpu_stb_i=1, the engine must not drive stb in the next cycle.
- States:
  - IDLE: cmd_valid=1 latches cmd_op and fill_word, sets index=0, busy=1, then goes to CLR_WR (op 0) or SC_RD (op 1).
  - CLR_WR: write fill_word to index. After the pair completes, index+1; when index = WORDS-1, go to FIN.
  - SC_RD: read address index+COLS. After the pair, go to SC_CAP.
  - SC_CAP: 1 cycle, stb=0; latch vram_dat_i into the holding register.
    - If a CPU cycle occurred in the read pair or in this cycle, go back to SC_RD.
    - Otherwise go to SC_WR.
  - SC_WR: write the holding register to index. After the pair, index+1.
    - If index = WORDS-COLS-1, go to SC_FILL.
    - Otherwise go to SC_RD.
  - SC_FILL: write fill_word to indices WORDS-COLS .. WORDS-1 (same pair rule), then go to FIN.
  - FIN: done=1 for one cycle, busy=0, then IDLE.
- cmd_valid while busy=1 is ignored (no queueing).
- cmd_valid in the same cycle as FIN is ignored.
- Addresses: vram_adr_o = {19'b0, index, 2'b00} for engine accesses. index never exceeds WORDS-1.
- Uncontended timing:
  - Clear takes 2*1200 + 2 = 2402 cycles from cmd_valid to the done pulse.
  - Scroll takes 1160*5 + 40*2 + 2 cycles.

Test Plan:
- Clear, no CPU traffic: cmd_op=0, fill_word=0x00000720 → all 1200 words read back 0x720; done pulses exactly once, 2402 cycles after cmd_valid; busy=0 afterwards.
- Scroll, no CPU traffic: preload word i=i, cmd_op=1, fill_word=0x20 → word i=i+40 for i<1160; words 1160..1199 = 0x20.
- CPU preemption: run a scroll while the CPU issues a random read/write every 3 cycles to a scratch address outside the copy path → scroll result identical to the previous scenario; every CPU read returns the correct data; no engine stb in any guard cycle.
- CPU write during a clear: CPU writes 0xDEADBEEF to word 5 after the engine has passed word 5 → word 5 = 0xDEADBEEF at the end; all other words = fill.
- Ignored command: pulse cmd_valid with op=1 at cycle 100 of a clear → clear completes normally, one done pulse, no scroll happens.
- Reset mid-clear: assert rst at index≈600 → busy=0 and done=0 immediately; words 0..~599 = fill, the rest unchanged; a new command afterwards runs normally.

Source files
------------

// File: rtl/vram_blit_arb.sv
// vram_blit_arb: shares the VRAM CPU port between the CPU bus and a clear/scroll engine
module vram_blit_arb #(
  parameter int COLS = 40,
  parameter int ROWS = 30,
  parameter int AW   = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_dat_i,
  input  logic [31:0] cpu_adr_i,
  input  logic        cpu_we_i,
  input  logic        cpu_stb_i,
  output logic [31:0] cpu_dat_o,
  output logic        cpu_ack_o,
  input  logic        cmd_valid,
  input  logic        cmd_op,
  input  logic [31:0] fill_word,
  output logic        busy,
  output logic        done,
  output logic [31:0] vram_dat_o,
  output logic [31:0] vram_adr_o,
  output logic        vram_we_o,
  output logic        vram_stb_o,
  input  logic [31:0] vram_dat_i
);
  localparam int WORDS = COLS * ROWS;
  typedef enum logic [2:0] {IDLE, CLR_WR, SC_RD, SC_CAP, SC_WR, SC_FILL, FIN} state_t;
  state_t        state, state_n;
  logic [AW-1:0] idx, idx_n, eadr;
  logic [31:0]   fill, hold;
  logic          ph, cpu_q, hit, acc, go, last, eng_we;
  // Engine drives the bus only in access states, never while the CPU owns it or in the cycle after.
  always_comb begin
    acc    = state inside {CLR_WR, SC_RD, SC_WR, SC_FILL};
    eng_we = state inside {CLR_WR, SC_WR, SC_FILL};
    go     = acc && !cpu_stb_i && !cpu_q;
    last   = go && ph;
    eadr   = state == SC_RD ? idx + AW'(COLS) : idx;
  end
  // Next-state and index update; an access advances only once its second pair cycle is uninterrupted.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    unique case (state)
      IDLE: if (cmd_valid) begin
        state_n = cmd_op ? SC_RD : CLR_WR;
        idx_n   = '0;
      end
      CLR_WR, SC_FILL: if (last) begin
        state_n = idx == AW'(WORDS - 1) ? FIN : state;
        idx_n   = idx == AW'(WORDS - 1) ? idx : idx + 1'b1;
      end
      SC_RD: if (last) state_n = SC_CAP;
      SC_CAP: state_n = (hit || cpu_stb_i) ? SC_RD : SC_WR;
      SC_WR: if (last) begin
        state_n = idx == AW'(WORDS - COLS - 1) ? SC_FILL : SC_RD;
        idx_n   = idx + 1'b1;
      end
      FIN: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // State, pair phase, guard history, and data holding registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      ph    <= 1'b0;
      cpu_q <= 1'b0;
      hit   <= 1'b0;
      fill  <= '0;
      hold  <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      ph    <= go && !ph;
      cpu_q <= cpu_stb_i;
      hit   <= (state_n == SC_RD && state != SC_RD) ? 1'b0 : (state == SC_RD && cpu_stb_i) ? 1'b1 : hit;
      fill  <= (state == IDLE && cmd_valid) ? fill_word : fill;
      hold  <= state == SC_CAP ? vram_dat_i : hold;
    end
  end
  // CPU has per-cycle priority on the shared port; an idle bus shows stb=0 and we=0.
  always_comb begin
    cpu_ack_o  = cpu_stb_i;
    cpu_dat_o  = vram_dat_i;
    vram_stb_o = cpu_stb_i || go;
    vram_we_o  = cpu_stb_i ? cpu_we_i : go && eng_we;
    vram_adr_o = cpu_stb_i ? cpu_adr_i : {{(30 - AW){1'b0}}, eadr, 2'b00};
    vram_dat_o = cpu_stb_i ? cpu_dat_i : (state == SC_WR ? hold : fill);
    busy       = !(state == IDLE || state == FIN);
    done       = state == FIN;
  end
endmodule
